vga_pll_sequencer: RTL



---
 rtl/vga_pll_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/vga_pll_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vga_pll_pkg.sv
// rtl/vga_pll_pkg.sv - shared types and constants for the VGA PLL sequencer
package vga_pll_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 500000;
    localparam int DEF_MAX_RETRIES  = 3;
    localparam int RELOCK_W         = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_pll_sequencer.sv
// rtl/vga_pll_sequencer.sv - PLL reset/lock sequencer with retry and relock tracking
module vga_pll_sequencer
    import vga_pll_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                restart,
    output logic                pll_rst,
    output logic                pll_ready,
    output logic                pll_fail,
    output logic [2:0]          state,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT) + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    pll_state_e          state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [RTY_W-1:0]    retries_q, retries_n;
    logic [RELOCK_W-1:0] relock_q, relock_n;
    logic                lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retries_q <= retries_n;
            relock_q  <= relock_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        retries_n = retries_q;
        relock_n  = relock_q;
        if (restart) begin
            state_n   = RESET_PLL;
            cnt_n     = '0;
            retries_n = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock seen on the final timeout cycle still wins over the retry.
                    if (lock_s) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        if (retries_q == RTY_W'(MAX_RETRIES)) begin
                            state_n = FAIL;
                        end else begin
                            state_n   = RESET_PLL;
                            cnt_n     = '0;
                            retries_n = retries_q + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    // A dropout here only restarts the wait; the PLL is left running.
                    if (!lock_s) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_n   = RUN;
                        retries_n = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_n = RESET_PLL;
                        cnt_n   = '0;
                        if (relock_q != '1) begin
                            relock_n = relock_q + 1'b1;
                        end
                    end
                end
                FAIL: begin
                    state_n = FAIL;
                end
                default: begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign pll_rst      = (state_q == RESET_PLL) || (state_q == FAIL);
    assign pll_ready    = (state_q == RUN);
    assign pll_fail     = (state_q == FAIL);
    assign state        = state_q;
    assign relock_count = relock_q;

endmodule
